// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter signal bundle of the shared-UART arbiter.
// slave = arbiter side, master = clients/transmitter side.
interface uart_tx_arbiter_if #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*8-1:0] req_data;
   logic [NREQ-1:0]   req_last;
   logic [NREQ-1:0]   req_ready;
   logic [7:0]        tx_din;
   logic              tx_wr_en;
   logic              tx_busy;
   logic [IDW-1:0]    grant_id;
   logic              arb_busy;

   modport slave (
      input  req_valid, req_data, req_last, tx_busy,
      output req_ready, tx_din, tx_wr_en, grant_id, arb_busy
   );

   modport master (
      output req_valid, req_data, req_last, tx_busy,
      input  req_ready, tx_din, tx_wr_en, grant_id, arb_busy
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART byte transmitter among NREQ requesters.
// Optional packet lock: define UART_TX_ARB_LOCK_EN.
//
// state     | meaning
// ARB       | wait for idle transmitter and a valid candidate, pick winner
// ISSUE     | one-cycle tx_wr_en / req_ready pulse for the latched byte
// WAIT_BUSY | wait for the transmitter to raise tx_busy
// WAIT_DONE | wait for the frame to finish (tx_busy low)
module uart_tx_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input logic             clk_50m,
   input logic             rst,
   uart_tx_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      ARB       = 2'd0,
      ISSUE     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [IDW-1:0]    grant_q, grant_d;
   logic [7:0]        din_q, din_d;
   logic              wr_en_q, wr_en_d;
   logic [NREQ-1:0]   ready_q, ready_d;
   logic              arb_busy_q, arb_busy_d;
`ifdef UART_TX_ARB_LOCK_EN
   logic              last_q, last_d;
   logic              lock_q, lock_d;
`endif

   logic              found;
   logic [IDW-1:0]    win;

   function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int off);
      return IDW'((int'(base) + off) % NREQ);
   endfunction

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      din_d    = din_q;
      wr_en_d  = 1'b0;
      ready_d  = '0;
`ifdef UART_TX_ARB_LOCK_EN
      last_d   = last_q;
      lock_d   = lock_q;
`endif
      found    = 1'b0;
      win      = grant_q;

      // search begins just after the last grant so every requester rotates to the front
      for (int k = 1; k <= NREQ; k++) begin
         if (!found && bus.req_valid[rr_idx(grant_q, k)]) begin
            found = 1'b1;
            win   = rr_idx(grant_q, k);
         end
      end

`ifdef UART_TX_ARB_LOCK_EN
      // mid-packet: only the owner may be picked, others wait
      if (lock_q) begin
         found = bus.req_valid[grant_q];
         win   = grant_q;
      end
`endif

      case (state_q)
         ARB: begin
            if (!bus.tx_busy && found) begin
               state_d      = ISSUE;
               grant_d      = win;
               din_d        = bus.req_data[{win, 3'b000} +: 8];
               wr_en_d      = 1'b1;
               ready_d[win] = 1'b1;
`ifdef UART_TX_ARB_LOCK_EN
               last_d       = bus.req_last[win];
`endif
            end
         end
         ISSUE: begin
            state_d = WAIT_BUSY;
`ifdef UART_TX_ARB_LOCK_EN
            lock_d  = !last_q;
`endif
         end
         WAIT_BUSY: if (bus.tx_busy)  state_d = WAIT_DONE;
         WAIT_DONE: if (!bus.tx_busy) state_d = ARB;
         default:   state_d = ARB;
      endcase

      arb_busy_d = (state_d != ARB);
   end

   always_ff @(posedge clk_50m) begin
      if (rst) begin
         state_q    <= ARB;
         grant_q    <= IDW'(NREQ - 1);
         din_q      <= 8'h00;
         wr_en_q    <= 1'b0;
         ready_q    <= '0;
         arb_busy_q <= 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
         last_q     <= 1'b0;
         lock_q     <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         din_q      <= din_d;
         wr_en_q    <= wr_en_d;
         ready_q    <= ready_d;
         arb_busy_q <= arb_busy_d;
`ifdef UART_TX_ARB_LOCK_EN
         last_q     <= last_d;
         lock_q     <= lock_d;
`endif
      end
   end

   assign bus.tx_din    = din_q;
   assign bus.tx_wr_en  = wr_en_q;
   assign bus.req_ready = ready_q;
   assign bus.grant_id  = grant_q;
   assign bus.arb_busy  = arb_busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queued requester models, a frame-timed
// transmitter model and a write monitor feeding immediate-assertion checks.
module tb_uart_tx_arbiter;
   localparam int NREQ  = 4;
   localparam int IDW   = 2;
   localparam int FRAME = 40;

   logic clk_50m = 1'b0;
   logic rst     = 1'b1;

   uart_tx_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();
   uart_tx_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (.clk_50m(clk_50m), .rst(rst), .bus(bus));

   always #10 clk_50m = ~clk_50m;

   // requester models: byte rings (written by the stimulus) plus an endless-byte mode
   logic [7:0] mem   [NREQ][16];
   logic       mlast [NREQ][16];
   int         tail  [NREQ];
   int         rd_ptr[NREQ] = '{default: 0};
   logic       inf_en  [NREQ];
   logic [7:0] inf_byte[NREQ];

   always_comb begin
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.req_last  = '0;
      for (int i = 0; i < NREQ; i++) begin
         bus.req_valid[i]       = inf_en[i] || (rd_ptr[i] != tail[i]);
         bus.req_data[i*8 +: 8] = inf_en[i] ? inf_byte[i] : mem[i][rd_ptr[i] % 16];
         bus.req_last[i]        = inf_en[i] ? 1'b1 : mlast[i][rd_ptr[i] % 16];
      end
   end

   always @(posedge clk_50m)
      for (int i = 0; i < NREQ; i++)
         if (bus.req_ready[i] && !inf_en[i] && rd_ptr[i] != tail[i]) rd_ptr[i] <= rd_ptr[i] + 1;

   // transmitter model: no reset, busy for FRAME cycles after a write
   logic busy_m = 1'b0;
   int   fcnt   = 0;
   assign bus.tx_busy = busy_m;
   always @(posedge clk_50m) begin
      if (busy_m) begin
         if (fcnt == 0) busy_m <= 1'b0;
         else           fcnt   <= fcnt - 1;
      end else if (bus.tx_wr_en) begin
         busy_m <= 1'b1;
         fcnt   <= FRAME - 1;
      end
   end

   // write monitor
   int         cyc = 0;
   logic [7:0] log_q[$];
   int         gap_log[$];
   int         fall_cyc  = 0;
   logic       busy_prev = 1'b0;
   int         bad_ready = 0;
   int         wr_busy   = 0;

   always @(posedge clk_50m) cyc <= cyc + 1;

   always @(negedge clk_50m) begin
      if (busy_prev && !bus.tx_busy) fall_cyc = cyc;
      busy_prev = bus.tx_busy;
      if (bus.tx_wr_en) begin
         log_q.push_back(bus.tx_din);
         gap_log.push_back(cyc - fall_cyc);
         if (bus.req_ready != (NREQ'(1) << bus.grant_id)) bad_ready++;
         if (bus.tx_busy) wr_busy++;
      end else if (bus.req_ready != '0) begin
         bad_ready++;
      end
   end

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk_50m);
      #1;
   endtask

   task automatic load(input int r, input logic [7:0] b, input logic l);
      mem[r][tail[r] % 16]   = b;
      mlast[r][tail[r] % 16] = l;
      tail[r] = tail[r] + 1;
   endtask

   task automatic wait_log(input string tag, input int target);
      int t = 0;
      while (log_q.size() < target && t < 3000) begin step(1); t++; end
      chk(tag, log_q.size(), target);
   endtask

   task automatic wait_idle(input string tag);
      int t = 0;
      while ((bus.tx_busy || bus.arb_busy) && t < 3000) begin step(1); t++; end
      chk(tag, {bus.tx_busy, bus.arb_busy}, 0);
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      step(1);
      rst = 1'b0;
   endtask

   int mark;
   int nexp;
   logic [7:0] lock_exp[5];

   initial begin
      for (int i = 0; i < NREQ; i++) begin
         tail[i]     = 0;
         inf_en[i]   = 1'b0;
         inf_byte[i] = 8'h00;
      end
      step(3);
      chk("rst_ready",    bus.req_ready, 0);
      chk("rst_wr_en",    bus.tx_wr_en,  0);
      chk("rst_din",      bus.tx_din,    8'h00);
      chk("rst_grant",    bus.grant_id,  3);
      chk("rst_arb_busy", bus.arb_busy,  0);
      rst = 1'b0;
      step(1);

      // single byte, one-cycle latency from valid to ISSUE
      load(0, 8'h55, 1'b1);
      step(1);
      chk("single_wr_en", bus.tx_wr_en,  1);
      chk("single_din",   bus.tx_din,    8'h55);
      chk("single_ready", bus.req_ready, 4'b0001);
      step(1);
      chk("single_wr_en_off", bus.tx_wr_en,  0);
      chk("single_ready_off", bus.req_ready, 0);
      chk("single_arb_busy",  bus.arb_busy,  1);
      wait_idle("single_idle");
      chk("single_grant", bus.grant_id, 0);
      chk("single_count", log_q.size(), 1);

      // round-robin between two continuously valid requesters
      pulse_rst();
      mark = log_q.size();
      inf_byte[0] = 8'hA0; inf_byte[1] = 8'hB1;
      inf_en[0] = 1'b1;    inf_en[1] = 1'b1;
      wait_log("rr_wait", mark + 4);
      inf_en[0] = 1'b0;    inf_en[1] = 1'b0;
      wait_idle("rr_idle");
      chk("rr_b0", log_q[mark],     8'hA0);
      chk("rr_b1", log_q[mark + 1], 8'hB1);
      chk("rr_b2", log_q[mark + 2], 8'hA0);
      chk("rr_b3", log_q[mark + 3], 8'hB1);

      pulse_rst();
      mark = log_q.size();
      load(1, 8'h5A, 1'b1);
      wait_log("rr1_wait", mark + 1);
      chk("rr1_grant", bus.grant_id, 1);
      chk("rr1_data",  log_q[mark], 8'h5A);
      wait_idle("rr1_idle");

      // packet lock (or plain round-robin when the lock is not built)
      pulse_rst();
      mark = log_q.size();
`ifdef UART_TX_ARB_LOCK_EN
      nexp = 4;
      lock_exp = '{8'h01, 8'h02, 8'h03, 8'hFF, 8'h00};
`else
      nexp = 5;
      lock_exp = '{8'h01, 8'hFF, 8'h02, 8'hFF, 8'h03};
`endif
      load(0, 8'h01, 1'b0);
      load(0, 8'h02, 1'b0);
      load(0, 8'h03, 1'b1);
      inf_byte[2] = 8'hFF;
      inf_en[2]   = 1'b1;
      wait_log("lock_wait", mark + nexp);
      inf_en[2] = 1'b0;
      wait_idle("lock_idle");
      step(5);
      chk("lock_count", log_q.size(), mark + nexp);
      for (int k = 0; k < nexp; k++) chk($sformatf("lock_b%0d", k), log_q[mark + k], lock_exp[k]);

      // reset during a frame with req1 pending
      mark = log_q.size();
      load(0, 8'hC3, 1'b1);
      wait_log("mid_wait", mark + 1);
      step(10);
      load(1, 8'h77, 1'b1);
      step(2);
      pulse_rst();
      chk("mid_arb_busy", bus.arb_busy, 0);
      chk("mid_grant",    bus.grant_id, 3);
      chk("mid_din",      bus.tx_din,   8'h00);
      begin
         int t = 0;
         while (bus.tx_busy && t < 3000) begin
            chk("mid_no_ready", bus.req_ready, 0);
            step(1);
            t++;
         end
      end
      chk("mid_no_write", log_q.size(), mark + 1);
      wait_log("mid_req1", mark + 2);
      chk("mid_data", log_q[mark + 1], 8'h77);
      wait_idle("mid_idle");
      step(20);
      chk("mid_once", log_q.size(), mark + 2);

      // back-to-back stream from req3
      mark = log_q.size();
      for (int k = 0; k < 4; k++) load(3, 8'h10 + 8'(k), (k == 3));
      wait_log("b2b_wait", mark + 4);
      wait_idle("b2b_idle");
      step(5);
      chk("b2b_count", log_q.size(), mark + 4);
      for (int k = 0; k < 4; k++) chk($sformatf("b2b_b%0d", k), log_q[mark + k], 8'h10 + 8'(k));
      for (int k = 1; k < 4; k++) chk($sformatf("b2b_gap%0d", k), gap_log[mark + k], 2);
      chk("b2b_grant", bus.grant_id, 3);

      chk("ready_protocol", bad_ready, 0);
      chk("wr_while_busy",  wr_busy,   0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
